regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_scoreboard.sv | 78 +++++++
 rtl/regfile_sb.sv | 97 +++++++++
 tb/tb_regfile_sb.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the register file with scoreboard.
//   REGFILE_ADDR_W : default register address width (32 entries)
//   REGFILE_DATA_W : default register data width
//   ZERO_REG       : index of the hard-wired zero register
package regfile_pkg;

    localparam int REGFILE_ADDR_W = 5;
    localparam int REGFILE_DATA_W = 32;
    localparam int ZERO_REG       = 0;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for the register file.
// An issue marks a register as pending a write, and a writeback clears it.
// When an issue and a writeback hit the same register in one cycle, the
// issue wins. busy_cnt tracks the number of set bits incrementally.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   iss_en/iss_addr    : mark a register busy
//   w0_en/w0_addr      : writeback port 0 (clears busy)
//   w1_en/w1_addr      : writeback port 1 (clears busy)
//   busy               : registered busy vector, bit 0 always 0
//   busy_cnt           : registered popcount of busy
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REGFILE_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 iss_en,
    input  logic [ADDR_W-1:0]    iss_addr,
    input  logic                 w0_en,
    input  logic [ADDR_W-1:0]    w0_addr,
    input  logic                 w1_en,
    input  logic [ADDR_W-1:0]    w1_addr,
    output logic [2**ADDR_W-1:0] busy,
    output logic [ADDR_W:0]      busy_cnt
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic iss_v, w0_v, w1_v;
    logic set_inc, clr0_dec, clr1_dec;

    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment, so no path can leave it unassigned (no latch).
        iss_v = iss_en && (iss_addr != ZERO_A);
        w0_v  = w0_en  && (w0_addr  != ZERO_A);
        w1_v  = w1_en  && (w1_addr  != ZERO_A);

        busy_d = busy_q;
        if (w0_v) busy_d[w0_addr] = 1'b0;
        if (w1_v) busy_d[w1_addr] = 1'b0;
        // Issue is applied last so it overrides a same-address writeback.
        if (iss_v) busy_d[iss_addr] = 1'b1;
        busy_d[ZERO_REG] = 1'b0;

        // Count only real transitions: a set of an idle bit, or a clear of a
        // busy bit that is neither re-issued nor already cleared by w0.
        set_inc  = iss_v && !busy_q[iss_addr];
        clr0_dec = w0_v && busy_q[w0_addr] && !(iss_v && iss_addr == w0_addr);
        clr1_dec = w1_v && busy_q[w1_addr] && !(iss_v && iss_addr == w1_addr)
                   && !(w0_v && w0_addr == w1_addr);

        cnt_d = cnt_q + CNT_W'(set_inc) - CNT_W'(clr0_dec) - CNT_W'(clr1_dec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = cnt_q;

endmodule : regfile_scoreboard

// File: rtl/regfile_sb.sv
// Multi-read, dual-write register file with an issue/writeback scoreboard.
// Register 0 reads as zero, ignores writes and is never busy. Reads are
// combinational. Optional macro REGFILE_SB_BYPASS_EN forwards same-cycle
// write data to the read ports (w1 over w0) unless that register is also
// being issued in the same cycle.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   r_addr / r_data         : NRD packed read ports, port k at [k*W +: W]
//   r_busy                  : per read port, addressed register is pending
//   w0_*, w1_*              : writeback ports (w1 wins on same address)
//   iss_en / iss_addr       : mark a register pending
//   busy_cnt                : number of registers currently pending
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REGFILE_ADDR_W,
    parameter int DATA_W = REGFILE_DATA_W,
    parameter int NRD    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD*ADDR_W-1:0] r_addr,
    output logic [NRD*DATA_W-1:0] r_data,
    output logic [NRD-1:0]        r_busy,
    input  logic                  w0_en,
    input  logic [ADDR_W-1:0]     w0_addr,
    input  logic [DATA_W-1:0]     w0_data,
    input  logic                  w1_en,
    input  logic [ADDR_W-1:0]     w1_addr,
    input  logic [DATA_W-1:0]     w1_data,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    output logic [ADDR_W:0]       busy_cnt
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy;

    always_comb begin
        mem_d = mem_q;
        if (w0_en && w0_addr != ZERO_A) mem_d[w0_addr] = w0_data;
        // Applied after w0 so w1 wins on a same-address collision.
        if (w1_en && w1_addr != ZERO_A) mem_d[w1_addr] = w1_data;
        mem_d[ZERO_REG] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the array is deliberately reset -- reset must clear every
        // entry, which rules out a RAM macro and keeps it as flops.
        if (!rst_n) mem_q <= '{default: '0};
        else        mem_q <= mem_d;
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .w0_en    (w0_en),
        .w0_addr  (w0_addr),
        .w1_en    (w1_en),
        .w1_addr  (w1_addr),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    always_comb begin : read_mux
        logic [ADDR_W-1:0] ra;
        ra     = '0;
        r_data = '0;
        r_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            ra = r_addr[k*ADDR_W +: ADDR_W];
            r_data[k*DATA_W +: DATA_W] = mem_q[ra];
            r_busy[k]                  = busy[ra];
`ifdef REGFILE_SB_BYPASS_EN
            // Forwarding is gated by rst_n so outputs stay 0 during reset.
            if (rst_n && ra != ZERO_A && !(iss_en && iss_addr == ra)) begin
                if (w1_en && w1_addr == ra) begin
                    r_data[k*DATA_W +: DATA_W] = w1_data;
                    r_busy[k]                  = 1'b0;
                end else if (w0_en && w0_addr == ra) begin
                    r_data[k*DATA_W +: DATA_W] = w0_data;
                    r_busy[k]                  = 1'b0;
                end
            end
`endif
        end
    end

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// Scoreboard-style bench for regfile_sb (default parameters, NRD=2).
// Stimulus pushes hand-computed expectations into a queue; a monitor
// process pops and compares them whenever a sample is requested.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  r_addr;
    logic [63:0] r_data;
    logic [1:0]  r_busy;
    logic        w0_en, w1_en, iss_en;
    logic [4:0]  w0_addr, w1_addr, iss_addr;
    logic [31:0] w0_data, w1_data;
    logic [5:0]  busy_cnt;

    regfile_sb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .r_addr   (r_addr),
        .r_data   (r_data),
        .r_busy   (r_busy),
        .w0_en    (w0_en),
        .w0_addr  (w0_addr),
        .w0_data  (w0_data),
        .w1_en    (w1_en),
        .w1_addr  (w1_addr),
        .w1_data  (w1_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy_cnt (busy_cnt)
    );

    always #5 clk = ~clk;

    typedef enum int { S_RD0, S_RD1, S_BUSY0, S_BUSY1, S_CNT } sel_t;
    typedef struct {
        string       name;
        sel_t        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    event do_check;

    function automatic logic [31:0] actual(input sel_t sel);
        case (sel)
            S_RD0:   return r_data[31:0];
            S_RD1:   return r_data[63:32];
            S_BUSY0: return {31'b0, r_busy[0]};
            S_BUSY1: return {31'b0, r_busy[1]};
            default: return {26'b0, busy_cnt};
        endcase
    endfunction

    // Monitor: drains the expectation queue against live DUT outputs.
    initial begin
        exp_t e;
        logic [31:0] a;
        forever begin
            @(do_check);
            while (sbq.size() != 0) begin
                e = sbq.pop_front();
                a = actual(e.sel);
                checks++;
                if (a !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, a, e.exp);
                end
            end
        end
    end

    task automatic expect_val(input string name, input sel_t sel, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        sbq.push_back(e);
    endtask

    // Request a sample and wait (bounded) for the monitor to drain the queue.
    task automatic sample();
        #1;
        -> do_check;
        for (int i = 0; i < 20 && sbq.size() != 0; i++) #1;
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL monitor_timeout: got %0d pending, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic clear_inputs();
        w0_en = 1'b0; w0_addr = '0; w0_data = '0;
        w1_en = 1'b0; w1_addr = '0; w1_data = '0;
        iss_en = 1'b0; iss_addr = '0;
    endtask

    // Advance through one rising edge, then drop all write/issue requests.
    task automatic tick();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic set_raddr(input int a1, input int a0);
        r_addr = {5'(a1), 5'(a0)};
    endtask

    task automatic wr0(input int a, input logic [31:0] d);
        w0_en = 1'b1; w0_addr = 5'(a); w0_data = d;
    endtask

    task automatic wr1(input int a, input logic [31:0] d);
        w1_en = 1'b1; w1_addr = 5'(a); w1_data = d;
    endtask

    task automatic issue(input int a);
        iss_en = 1'b1; iss_addr = 5'(a);
    endtask

    initial begin
        // Reset held with write/issue traffic present across an edge.
        rst_n = 1'b0;
        clear_inputs();
        set_raddr(2, 3);
        wr0(3, 32'd55);
        issue(3);
        #12;
        expect_val("reset_rd0", S_RD0, 32'd0);
        expect_val("reset_busy0", S_BUSY0, 32'd0);
        expect_val("reset_cnt", S_CNT, 32'd0);
        sample();
        clear_inputs();
        rst_n = 1'b1;
        tick();
        expect_val("post_reset_discard_rd0", S_RD0, 32'd0);
        expect_val("post_reset_discard_cnt", S_CNT, 32'd0);
        sample();

        // Write/read: reg3=34 then reg2=7, ports {1:2, 0:3}.
        wr0(3, 32'd34);
        tick();
        expect_val("wr_reg3", S_RD0, 32'd34);
        expect_val("wr_reg2_not_yet", S_RD1, 32'd0);
        sample();
        wr0(2, 32'd7);
        tick();
        expect_val("wr_reg2", S_RD1, 32'd7);
        expect_val("wr_reg3_kept", S_RD0, 32'd34);
        sample();

        // Conflict: w1 wins; register 0 ignores writes.
        wr0(5, 32'd11);
        wr1(5, 32'd22);
        set_raddr(0, 5);
        tick();
        expect_val("conflict_w1_wins", S_RD0, 32'd22);
        sample();
        wr0(0, 32'd99);
        issue(0);
        tick();
        expect_val("zero_reg_read", S_RD1, 32'd0);
        expect_val("zero_reg_never_busy", S_CNT, 32'd0);
        sample();

        // Scoreboard: issue 4, 6, 4 again.
        set_raddr(6, 4);
        issue(4);
        tick();
        expect_val("cnt_after_iss4", S_CNT, 32'd1);
        sample();
        issue(6);
        tick();
        expect_val("cnt_after_iss6", S_CNT, 32'd2);
        sample();
        issue(4);
        tick();
        expect_val("cnt_reissue4", S_CNT, 32'd2);
        expect_val("busy4_set", S_BUSY0, 32'd1);
        sample();
        wr0(4, 32'd44);
        issue(6);
        tick();
        expect_val("cnt_clear4_reiss6", S_CNT, 32'd1);
        expect_val("busy4_cleared", S_BUSY0, 32'd0);
        expect_val("busy6_still", S_BUSY1, 32'd1);
        sample();

        // Same-address issue and writeback on reg 9: issue wins, +1 only.
        set_raddr(6, 9);
        issue(9);
        wr1(9, 32'd90);
        tick();
        expect_val("iss_wr_same_busy9", S_BUSY0, 32'd1);
        expect_val("iss_wr_same_cnt", S_CNT, 32'd2);
        expect_val("iss_wr_same_data9", S_RD0, 32'd90);
        sample();

        // Both write ports clearing reg 6 decrement once; clearing idle reg 5 is a no-op.
        wr0(6, 32'd60);
        wr1(6, 32'd61);
        tick();
        expect_val("dual_clear6_cnt", S_CNT, 32'd1);
        expect_val("dual_clear6_busy", S_BUSY1, 32'd0);
        sample();
        wr0(5, 32'd50);
        tick();
        expect_val("clear_idle_cnt", S_CNT, 32'd1);
        sample();

        // Bypass behaviour on reg 7 (old value 0x1111).
        set_raddr(0, 7);
        wr0(7, 32'h1111);
        tick();
        wr0(7, 32'hABCD);
`ifdef REGFILE_SB_BYPASS_EN
        expect_val("bypass_same_cycle", S_RD0, 32'hABCD);
`else
        expect_val("no_bypass_old", S_RD0, 32'h1111);
`endif
        sample();
        tick();
        expect_val("write7_visible", S_RD0, 32'hABCD);
        sample();

        // Mid-run asynchronous reset, away from any clock edge.
        set_raddr(9, 3);
        #2;
        expect_val("pre_reset_reg3", S_RD0, 32'd34);
        sample();
        rst_n = 1'b0;
        expect_val("async_reset_rd0", S_RD0, 32'd0);
        expect_val("async_reset_rd1", S_RD1, 32'd0);
        expect_val("async_reset_cnt", S_CNT, 32'd0);
        expect_val("async_reset_busy1", S_BUSY1, 32'd0);
        sample();

        #10;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regfile_sb
